// File: rtl/mma_icb_arbiter.sv
// N-channel ICB arbiter: fixed-priority or round-robin grant, held until the owner
// finishes, with a latched hold-time limit that forces release and flags a timeout.
module mma_icb_arbiter #(
    parameter int NUM_CH = 5,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_mode,
    input  logic [HOLD_W-1:0] cfg_hold_limit,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  icb_sel,
    output logic              busy,
    output logic              timeout_err,
    output logic [SEL_W-1:0]  timeout_ch
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt, hold_lim;
    logic               win_vld;
    logic [SEL_W-1:0]   win_idx, idx;
    int                 j;
    logic               own_end, hold_hit;
    logic               ld_grant, rel, force_rel;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        j       = 0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            j = arb_mode ? int'(rr_ptr) + i : i;
            if (j >= NUM_CH) j = j - NUM_CH;
            idx = SEL_W'(j);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // While granted, icb_sel names the owner; an owner dropping req ends like done.
    assign own_end  = done[icb_sel] || !req[icb_sel];
    assign hold_hit = (hold_lim != '0) && (hold_cnt == hold_lim);
    assign busy     = |grant;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (win_vld) state_nxt = S_GRANT;
            S_GRANT:   if (own_end || hold_hit) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_grant  = 1'b0;
        rel       = 1'b0;
        force_rel = 1'b0;
        case (state)
            S_IDLE:  ld_grant = win_vld;
            S_GRANT: begin
                rel       = own_end;
                force_rel = !own_end && hold_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            icb_sel     <= '0;
            timeout_err <= 1'b0;
            timeout_ch  <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            hold_lim    <= '0;
        end else begin
            timeout_err <= 1'b0;
            if (ld_grant) begin
                grant    <= NUM_CH'(1) << win_idx;
                icb_sel  <= win_idx;
                hold_cnt <= HOLD_W'(1);
                hold_lim <= cfg_hold_limit;
                if (arb_mode)
                    rr_ptr <= (win_idx == SEL_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
            end else if (rel) begin
                grant <= '0;
            end else if (force_rel) begin
                grant       <= '0;
                timeout_err <= 1'b1;
                timeout_ch  <= icb_sel;
            end else if (state == S_GRANT && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mma_icb_arbiter.sv
// Directed bench for mma_icb_arbiter: a per-cycle vector table plus hand-written
// sequences for round-robin rotation, fixed-priority starvation and reset mid-grant.
module tb_mma_icb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arb_mode;
    logic [15:0] cfg_hold_limit;
    logic [4:0]  req, done;
    logic [4:0]  grant;
    logic [2:0]  icb_sel, timeout_ch;
    logic        busy, timeout_err;

    int n_run  = 0;
    int n_fail = 0;

    mma_icb_arbiter dut (
        .clk(clk), .rst(rst), .arb_mode(arb_mode), .cfg_hold_limit(cfg_hold_limit),
        .req(req), .done(done), .grant(grant), .icb_sel(icb_sel), .busy(busy),
        .timeout_err(timeout_err), .timeout_ch(timeout_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        m;
        logic [15:0] lim;
        logic [4:0]  rq;
        logic [4:0]  dn;
        logic [4:0]  eg;
        logic [2:0]  es;
        logic        eto;
        logic [2:0]  etc;
    } vec_t;

    vec_t vec[29];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_grant(output logic [4:0] g);
        g = '0;
        for (int c = 0; c < 6 && g == '0; c++) begin
            tick();
            g = grant;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] g, e;

        // r m lim req done | grant sel to toch
        vec[0]  = '{1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0};
        vec[1]  = '{0, 0, 0, 5'b10100, 5'b00000, 5'b00100, 2, 0, 0};
        vec[2]  = '{0, 0, 0, 5'b10100, 5'b00000, 5'b00100, 2, 0, 0};
        vec[3]  = '{0, 0, 0, 5'b10100, 5'b00100, 5'b00000, 2, 0, 0};
        vec[4]  = '{0, 0, 0, 5'b10000, 5'b00000, 5'b00000, 2, 0, 0};
        vec[5]  = '{0, 0, 0, 5'b10000, 5'b00000, 5'b10000, 4, 0, 0};
        vec[6]  = '{0, 0, 0, 5'b10000, 5'b10000, 5'b00000, 4, 0, 0};
        vec[7]  = '{0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 4, 0, 0};
        // hold limit 4, ch3 never finishes: 4 grant cycles then timeout
        vec[8]  = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 0};
        vec[9]  = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 0};
        vec[10] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 0};
        vec[11] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 0};
        vec[12] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b00000, 3, 1, 3};
        vec[13] = '{0, 0, 4, 5'b00000, 5'b00000, 5'b00000, 3, 0, 3};
        // done arrives on the 4th grant cycle: normal release wins
        vec[14] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 3};
        vec[15] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 3};
        vec[16] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 3};
        vec[17] = '{0, 0, 4, 5'b01000, 5'b00000, 5'b01000, 3, 0, 3};
        vec[18] = '{0, 0, 4, 5'b01000, 5'b01000, 5'b00000, 3, 0, 3};
        vec[19] = '{0, 0, 4, 5'b00000, 5'b00000, 5'b00000, 3, 0, 3};
        // ch1 drops req mid-grant: abort without error
        vec[20] = '{0, 0, 4, 5'b00010, 5'b00000, 5'b00010, 1, 0, 3};
        vec[21] = '{0, 0, 4, 5'b00010, 5'b00000, 5'b00010, 1, 0, 3};
        vec[22] = '{0, 0, 4, 5'b00000, 5'b00000, 5'b00000, 1, 0, 3};
        vec[23] = '{0, 0, 4, 5'b00000, 5'b00000, 5'b00000, 1, 0, 3};
        // limit latched as 0 at grant; later limit change and foreign done ignored
        vec[24] = '{0, 0, 0, 5'b00010, 5'b00000, 5'b00010, 1, 0, 3};
        vec[25] = '{0, 0, 1, 5'b00010, 5'b00001, 5'b00010, 1, 0, 3};
        vec[26] = '{0, 0, 1, 5'b00010, 5'b00001, 5'b00010, 1, 0, 3};
        vec[27] = '{0, 0, 1, 5'b00010, 5'b00010, 5'b00000, 1, 0, 3};
        vec[28] = '{0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 1, 0, 3};

        rst = 1'b1; arb_mode = 1'b0; cfg_hold_limit = '0; req = '0; done = '0;

        for (int i = 0; i < 29; i++) begin
            rst = vec[i].r; arb_mode = vec[i].m; cfg_hold_limit = vec[i].lim;
            req = vec[i].rq; done = vec[i].dn;
            tick();
            chk($sformatf("vec%0d_grant", i), grant, vec[i].eg);
            chk($sformatf("vec%0d_sel", i), icb_sel, vec[i].es);
            chk($sformatf("vec%0d_busy", i), busy, |vec[i].eg);
            chk($sformatf("vec%0d_tout", i), timeout_err, vec[i].eto);
            chk($sformatf("vec%0d_tch", i), timeout_ch, vec[i].etc);
        end

        // Round-robin with all channels requesting: 0,1,2,3,4,0
        rst = 1'b1; req = '0; done = '0; cfg_hold_limit = '0;
        tick();
        rst = 1'b0; arb_mode = 1'b1; req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g);
            e = 5'(1 << (k % 5));
            chk($sformatf("rr_order%0d", k), g, e);
            tick(); tick();
            done = g;
            tick();
            done = '0;
            chk($sformatf("rr_rel%0d", k), grant, 5'b00000);
        end

        // Fixed priority: channel 0 starves the rest
        arb_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk($sformatf("fix_order%0d", k), g, 5'b00001);
            tick(); tick();
            done = g;
            tick();
            done = '0;
        end

        // Move rr_ptr to 2 via an RR grant of ch1, then grant ch3 in fixed mode
        arb_mode = 1'b1; req = 5'b00010;
        wait_grant(g);
        chk("pre_rr_ch1", g, 5'b00010);
        done = 5'b00010; tick(); done = '0; req = '0;
        tick();
        arb_mode = 1'b0; req = 5'b01000;
        wait_grant(g);
        chk("pre_fix_ch3", g, 5'b01000);

        // Reset mid-grant, then RR restarts from pointer 0
        rst = 1'b1; arb_mode = 1'b1; req = 5'b01010;
        tick();
        chk("rst_grant", grant, 5'b00000);
        chk("rst_sel", icb_sel, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tout", timeout_err, 1'b0);
        chk("rst_tch", timeout_ch, 3'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_grant", grant, 5'b00010);
        chk("post_rst_sel", icb_sel, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
